seg7_scan_driver: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display in the stopwatch design. It accepts a packed vector of 4-bit digit codes and per-digit decimal-point requests, and scans the digits one at a time with a programmable dwell and anti-ghosting gap. Decimal or hex glyphs are selectable, with optional leading-zero blanking. It sits between the stopwatch counter/BCD logic and the board display pins.

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/seg7_glyph_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared glyph constants, scan state encoding and the code-to-glyph function
// used by the seven-segment scan driver. All glyphs are active-low {a,b,c,d,e,f,g}.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'b0000001;
    localparam logic [6:0] SEG_1    = 7'b1001111;
    localparam logic [6:0] SEG_2    = 7'b0010010;
    localparam logic [6:0] SEG_3    = 7'b0000110;
    localparam logic [6:0] SEG_4    = 7'b1001100;
    localparam logic [6:0] SEG_5    = 7'b0100100;
    localparam logic [6:0] SEG_6    = 7'b0100000;
    localparam logic [6:0] SEG_7    = 7'b0001111;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0000100;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_B    = 7'b1100000;
    localparam logic [6:0] SEG_C    = 7'b0110001;
    localparam logic [6:0] SEG_D    = 7'b1000010;
    localparam logic [6:0] SEG_E    = 7'b0110000;
    localparam logic [6:0] SEG_F    = 7'b0111000;
    localparam logic [6:0] SEG_DASH = 7'b1111110;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    typedef enum logic [1:0] {
        OFF,
        GAP,
        DRIVE
    } scan_state_t;

    function automatic logic [6:0] seg7_glyph(input logic [3:0] code, input logic hex_mode);
        logic [6:0] g;
        case (code)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            4'd10:   g = hex_mode ? SEG_A : SEG_DASH;
            4'd11:   g = hex_mode ? SEG_B : SEG_DASH;
            4'd12:   g = hex_mode ? SEG_C : SEG_DASH;
            4'd13:   g = hex_mode ? SEG_D : SEG_DASH;
            4'd14:   g = hex_mode ? SEG_E : SEG_DASH;
            default: g = hex_mode ? SEG_F : SEG_DASH;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational 4-bit code to active-low seven-segment glyph lookup.
// Codes 10-15 render as hex letters or as a dash depending on HEX_MODE.
module seg7_glyph_decode
    import seg7_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = seg7_glyph(code, HEX_MODE);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode display driver: each digit slot is a
// dark anti-ghosting gap followed by a drive phase; outputs are registered.
//   state | meaning
//   OFF   | display dark, waiting for enable; counters and index held at 0
//   GAP   | first GAP_CYCLES cycles of a slot, all anodes off
//   DRIVE | remainder of the slot, anode idx on with its glyph
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 100000,
    parameter int GAP_CYCLES   = 2,
    parameter bit HEX_MODE     = 1'b0,
    parameter bit LZ_BLANK     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int CW = $clog2(DIGIT_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    scan_state_t             state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    snap_load;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_run;
    logic [3:0]              code_sel;
    logic [6:0]              glyph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= OFF;
            cnt         <= '0;
            idx         <= '0;
            snap_digits <= '0;
            snap_dp     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (snap_load) begin
                snap_digits <= digits_in;
                snap_dp     <= dp_in;
            end
        end
    end

    // The snapshot is reloaded on every entry to GAP(0): from OFF or on frame wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        snap_load = 1'b0;
        if (!enable) begin
            state_nxt = OFF;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                OFF: begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    snap_load = 1'b1;
                end
                GAP: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == GAP_LAST) state_nxt = DRIVE;
                end
                DRIVE: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = GAP;
                        if (idx == IDX_LAST) begin
                            idx_nxt   = '0;
                            snap_load = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = OFF;
            endcase
        end
    end

    // Walk down from the top digit; blanking ends at the first nonzero code or set dp.
    always_comb begin
        blank    = '0;
        zero_run = LZ_BLANK;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && (snap_digits[4*i +: 4] == 4'd0) && !snap_dp[i];
            blank[i] = zero_run;
        end
    end

    assign code_sel = snap_digits[{idx, 2'b00} +: 4];

    seg7_glyph_decode #(
        .HEX_MODE(HEX_MODE)
    ) u_glyph (
        .code(code_sel),
        .seg (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else if (!enable || state != DRIVE) begin
            an         <= '1;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= ~(NUM_DIGITS'(1) << idx);
            seg        <= blank[idx] ? SEG_OFF : glyph;
            dp         <= ~snap_dp[idx];
            frame_done <= (idx == IDX_LAST) && (cnt == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a decimal/blanking instance and a hex/no-blanking
// instance share stimulus; a position-based reference model checks every cycle.
module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DC    = 8;
    localparam int GC    = 2;
    localparam int FRAME = N * DC;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in     = 4'h0;

    logic [6:0] seg_d, seg_h;
    logic       dp_d, dp_h, fd_d, fd_h;
    logic [3:0] an_d, an_h;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(N), .DIGIT_CYCLES(DC), .GAP_CYCLES(GC), .HEX_MODE(1'b0), .LZ_BLANK(1'b1)
    ) u_dec (
        .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
        .seg(seg_d), .dp(dp_d), .an(an_d), .frame_done(fd_d)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(N), .DIGIT_CYCLES(DC), .GAP_CYCLES(GC), .HEX_MODE(1'b1), .LZ_BLANK(1'b0)
    ) u_hex (
        .clk(clk), .reset(reset), .enable(enable), .digits_in(digits_in), .dp_in(dp_in),
        .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [3:0] c, input bit hex);
        case (c)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: ;
        endcase
        if (!hex) return 7'b1111110;
        case (c)
            4'd10:   return 7'b0001000;
            4'd11:   return 7'b1100000;
            4'd12:   return 7'b0110001;
            4'd13:   return 7'b1000010;
            4'd14:   return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // A digit is blanked when it and every digit above it are zero with no dp.
    function automatic bit ref_blank(input logic [15:0] d, input logic [3:0] p, input int slot, input bit lz);
        if (!lz || slot == 0) return 1'b0;
        for (int j = slot; j < N; j++)
            if (d[4*j +: 4] != 4'd0 || p[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [12:0] ref_out(input bit on, input int pos, input logic [15:0] d,
                                            input logic [3:0] p, input bit hex, input bit lz);
        int         slot, ph;
        logic [3:0] a;
        logic [6:0] s;
        logic       dpo, f;
        slot = (pos / DC) % N;
        ph   = pos % DC;
        a    = 4'hF;
        s    = 7'h7F;
        dpo  = 1'b1;
        if (on && ph >= GC) begin
            a   = ~(4'b0001 << slot);
            s   = ref_blank(d, p, slot, lz) ? 7'h7F : ref_glyph(d[4*slot +: 4], hex);
            dpo = ~p[slot];
        end
        f = on && (ph == DC - 1) && (slot == N - 1);
        return {a, s, dpo, f};
    endfunction

    // Model: free-running position since scan start, snapshot every FRAME positions.
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_dig = '0;
    logic [3:0]  m_dp  = '0;
    bit          e_on  = 1'b0;
    int          e_pos = 0;
    logic [15:0] e_dig = '0;
    logic [3:0]  e_dpv = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 1'b0;
            m_pos = 0;
            m_dig = '0;
            m_dp  = '0;
            e_on  = 1'b0;
        end else begin
            e_on  = m_run && enable;
            e_pos = m_pos;
            e_dig = m_dig;
            e_dpv = m_dp;
            if (!enable) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1;
                m_pos = 0;
                m_dig = digits_in;
                m_dp  = dp_in;
            end else begin
                m_pos++;
                if (m_pos % FRAME == 0) begin
                    m_dig = digits_in;
                    m_dp  = dp_in;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_dec", {an_d, seg_d, dp_d, fd_d}, ref_out(e_on, e_pos, e_dig, e_dpv, 1'b0, 1'b1));
        chk("model_hex", {an_h, seg_h, dp_h, fd_h}, ref_out(e_on, e_pos, e_dig, e_dpv, 1'b1, 1'b0));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        bit          hex;
        int          slot;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int first_fd, cnt_fd;

        tbl.push_back('{16'h1234, 4'h0, 1'b1, 0, 4'b1110, 7'b1001100, 1'b1});
        tbl.push_back('{16'h1234, 4'h0, 1'b1, 1, 4'b1101, 7'b0000110, 1'b1});
        tbl.push_back('{16'h1234, 4'h0, 1'b1, 2, 4'b1011, 7'b0010010, 1'b1});
        tbl.push_back('{16'h1234, 4'h0, 1'b1, 3, 4'b0111, 7'b1001111, 1'b1});
        tbl.push_back('{16'h0070, 4'h0, 1'b0, 3, 4'b0111, 7'b1111111, 1'b1});
        tbl.push_back('{16'h0070, 4'h0, 1'b0, 2, 4'b1011, 7'b1111111, 1'b1});
        tbl.push_back('{16'h0070, 4'h0, 1'b0, 1, 4'b1101, 7'b0001111, 1'b1});
        tbl.push_back('{16'h0070, 4'h0, 1'b0, 0, 4'b1110, 7'b0000001, 1'b1});
        tbl.push_back('{16'h0070, 4'h4, 1'b0, 2, 4'b1011, 7'b0000001, 1'b0});
        tbl.push_back('{16'h0070, 4'h4, 1'b0, 3, 4'b0111, 7'b1111111, 1'b1});
        tbl.push_back('{16'hABCD, 4'h0, 1'b1, 0, 4'b1110, 7'b1000010, 1'b1});
        tbl.push_back('{16'hABCD, 4'h0, 1'b1, 3, 4'b0111, 7'b0001000, 1'b1});
        tbl.push_back('{16'hABCD, 4'h0, 1'b0, 0, 4'b1110, 7'b1111110, 1'b1});
        tbl.push_back('{16'hABCD, 4'h0, 1'b0, 3, 4'b0111, 7'b1111110, 1'b1});
        tbl.push_back('{16'h0000, 4'h0, 1'b0, 0, 4'b1110, 7'b0000001, 1'b1});
        tbl.push_back('{16'h0000, 4'h0, 1'b1, 3, 4'b0111, 7'b0000001, 1'b1});

        // Reset held with enable high, then released.
        @(negedge clk);
        enable = 1'b1;
        step(2);
        chk("rst_an", an_d, 4'b1111);
        chk("rst_seg", seg_d, 7'b1111111);
        chk("rst_dp", dp_d, 1'b1);
        chk("rst_fd", fd_d, 1'b0);
        reset = 1'b0;
        step(3);
        chk("rel_an_gap", an_d, 4'b1111);
        step(1);
        chk("rel_an_drive", an_d, 4'b1110);
        chk("rel_an_drive_hex", an_h, 4'b1110);

        foreach (tbl[k]) begin
            digits_in = tbl[k].d;
            dp_in     = tbl[k].p;
            restart();
            step(DC * tbl[k].slot + GC + 2);
            if (tbl[k].hex) begin
                chk($sformatf("tbl%0d_an", k), an_h, tbl[k].an);
                chk($sformatf("tbl%0d_seg", k), seg_h, tbl[k].seg);
                chk($sformatf("tbl%0d_dp", k), dp_h, tbl[k].dp);
            end else begin
                chk($sformatf("tbl%0d_an", k), an_d, tbl[k].an);
                chk($sformatf("tbl%0d_seg", k), seg_d, tbl[k].seg);
                chk($sformatf("tbl%0d_dp", k), dp_d, tbl[k].dp);
            end
        end

        // Inputs change mid-frame; only the next frame sees them.
        digits_in = 16'h1111;
        dp_in     = 4'h0;
        restart();
        step(DC + GC + 3);
        chk("snap_d1_an", an_h, 4'b1101);
        chk("snap_d1_seg", seg_h, 7'b1001111);
        digits_in = 16'h2222;
        step(DC);
        chk("snap_d2_seg", seg_h, 7'b1001111);
        step(DC);
        chk("snap_d3_seg", seg_h, 7'b1001111);
        step(DC);
        chk("snap_next_an", an_h, 4'b1110);
        chk("snap_next_seg", seg_h, 7'b0010010);

        // frame_done period.
        restart();
        step(1);
        first_fd = -1;
        cnt_fd   = 0;
        for (int j = 0; j < 3 * FRAME; j++) begin
            step(1);
            if (fd_d) begin
                cnt_fd++;
                if (first_fd < 0) first_fd = j;
            end
        end
        chk("fd_count", cnt_fd, 3);
        chk("fd_first", first_fd, FRAME - 1);

        // enable dropped during DRIVE(2).
        digits_in = 16'h5678;
        restart();
        step(2 * DC + GC + 2);
        chk("en_drive2_an", an_h, 4'b1011);
        enable = 1'b0;
        step(1);
        chk("en_off_an", an_h, 4'b1111);
        chk("en_off_seg", seg_h, 7'b1111111);
        chk("en_off_dec_an", an_d, 4'b1111);
        cnt_fd = 0;
        for (int j = 0; j < 2 * DC; j++) begin
            step(1);
            if (fd_h || fd_d) cnt_fd++;
        end
        chk("en_off_no_fd", cnt_fd, 0);
        enable = 1'b1;
        step(3);
        chk("en_re_gap_an", an_h, 4'b1111);
        step(1);
        chk("en_re_an", an_h, 4'b1110);
        chk("en_re_seg", seg_h, 7'b0000000);

        // Reset one cycle before the frame_done cycle.
        restart();
        step(3 * DC + GC + 2 + 4);
        chk("rstmid_pre_an", an_h, 4'b0111);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_an", an_h, 4'b1111);
        chk("rstmid_seg", seg_h, 7'b1111111);
        chk("rstmid_dp", dp_h, 1'b1);
        step(1);
        chk("rstmid_no_fd", {fd_h, fd_d}, 2'b00);
        reset = 1'b0;
        step(3);
        chk("rstmid_re_gap_an", an_h, 4'b1111);
        step(1);
        chk("rstmid_re_an", an_h, 4'b1110);

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (reset) reset = 1'b0;
            if ($urandom_range(0, 11) == 0) begin
                digits_in = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp_in     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
            if (enable && $urandom_range(0, 99) == 0)
                enable = 1'b0;
            else if (!enable && $urandom_range(0, 2) == 0)
                enable = 1'b1;
            if ($urandom_range(0, 399) == 0) begin
                #2 reset = 1'b1;
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
